pw_trigger_sequencer: RTL and testbench

- Generates the trigger output pulse train from the per-pulse delay/width/count configuration held in the main register block.
- Waits for an armed pattern match, then plays up to pNUM_TRIGGER_PULSES pulses, each with its own delay and width.
- Sits in the trigger clock domain, between the pattern matcher and the trigger I/O pin.
- All configuration inputs are already synchronised quasi-static levels.

---
 rtl/pw_trigger_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pw_trigger_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pw_trigger_sequencer
// Brief    : Plays a train of up to pNUM_TRIGGER_PULSES delayed trigger pulses
//            after an armed, enabled pattern match.
// Revision : 1.0
// ============================================================================
module pw_trigger_sequencer #(
    parameter int pNUM_TRIGGER_PULSES = 8,
    parameter int pNUM_TRIGGER_WIDTH  = 4,
    parameter int pDELAY_WIDTH        = 24
) (
    input  logic                                         trigger_clk,
    input  logic                                         reset_i,
    input  logic                                         I_arm,
    input  logic                                         I_trigger_enable,
    input  logic                                         I_match,
    input  logic [pNUM_TRIGGER_WIDTH-1:0]                I_num_triggers,
    input  logic [pDELAY_WIDTH*pNUM_TRIGGER_PULSES-1:0]  I_trigger_delay,
    input  logic [pDELAY_WIDTH*pNUM_TRIGGER_PULSES-1:0]  I_trigger_width,
    output logic                                         O_trigger,
    output logic                                         O_busy,
    output logic                                         O_done,
    output logic [pNUM_TRIGGER_WIDTH-1:0]                O_pulse_index,
    output logic                                         O_match_overrun
);

    localparam int IDX_W = (pNUM_TRIGGER_PULSES > 1) ? $clog2(pNUM_TRIGGER_PULSES) : 1;
    localparam logic [pNUM_TRIGGER_WIDTH-1:0] C_MAX_N = pNUM_TRIGGER_WIDTH'(pNUM_TRIGGER_PULSES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [pDELAY_WIDTH-1:0]         cnt_q, cnt_d;
    logic [pNUM_TRIGGER_WIDTH-1:0]   idx_q, idx_d;
    logic                            trig_q, trig_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            ovr_q, ovr_d;
    logic                            arm_q;

    logic [pDELAY_WIDTH-1:0]         dly_q [pNUM_TRIGGER_PULSES];
    logic [pDELAY_WIDTH-1:0]         wid_q [pNUM_TRIGGER_PULSES];
    logic [pNUM_TRIGGER_WIDTH-1:0]   last_idx_q;

    logic                            w_go;
    logic                            w_start;
    logic [pNUM_TRIGGER_WIDTH-1:0]   w_last_idx;
    logic [pNUM_TRIGGER_WIDTH-1:0]   w_idx_nxt;

    // Counters reload with (value-1) and fire at zero, so a field of all ones
    // never needs a wider counter; a zero field behaves like one.
    function automatic logic [pDELAY_WIDTH-1:0] min1_m1(input logic [pDELAY_WIDTH-1:0] v);
        return (v == '0) ? '0 : v - pDELAY_WIDTH'(1);
    endfunction

    assign w_go      = I_arm & I_trigger_enable;
    assign w_start   = (state_q == ST_IDLE) & I_match & w_go;
    assign w_idx_nxt = idx_q + pNUM_TRIGGER_WIDTH'(1);

    always_comb begin
        w_last_idx = I_num_triggers - pNUM_TRIGGER_WIDTH'(1);
        if (I_num_triggers == '0) begin
            w_last_idx = '0;
        end else if (I_num_triggers > C_MAX_N) begin
            w_last_idx = C_MAX_N - pNUM_TRIGGER_WIDTH'(1);
        end
    end

    generate
        for (genvar k = 0; k < pNUM_TRIGGER_PULSES; k++) begin : g_snap
            always_ff @(posedge trigger_clk) begin
                if (w_start) begin
                    dly_q[k] <= I_trigger_delay[k*pDELAY_WIDTH +: pDELAY_WIDTH];
                    wid_q[k] <= I_trigger_width[k*pDELAY_WIDTH +: pDELAY_WIDTH];
                end
            end
        end
    endgenerate

    always_ff @(posedge trigger_clk) begin
        if (w_start) begin
            last_idx_q <= w_last_idx;
        end
    end

    always_ff @(posedge trigger_clk) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            arm_q   <= I_arm;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        trig_d  = trig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        // Set wins over clear so a match coinciding with re-arm is not lost.
        if (I_arm && !arm_q) begin
            ovr_d = 1'b0;
        end
        if (I_match && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end

        if (!w_go && ((state_q == ST_DELAY) || (state_q == ST_HIGH))) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
            busy_d  = 1'b0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    trig_d = 1'b0;
                    busy_d = 1'b0;
                    idx_d  = '0;
                    if (w_start) begin
                        state_d = ST_DELAY;
                        cnt_d   = I_trigger_delay[pDELAY_WIDTH-1:0];
                        busy_d  = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_HIGH;
                        trig_d  = 1'b1;
                        cnt_d   = min1_m1(wid_q[idx_q[IDX_W-1:0]]);
                    end else begin
                        cnt_d = cnt_q - pDELAY_WIDTH'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == '0) begin
                        trig_d = 1'b0;
                        if (idx_q == last_idx_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_DELAY;
                            idx_d   = w_idx_nxt;
                            cnt_d   = min1_m1(dly_q[w_idx_nxt[IDX_W-1:0]]);
                        end
                    end else begin
                        cnt_d = cnt_q - pDELAY_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    trig_d  = 1'b0;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign O_trigger       = trig_q;
    assign O_busy          = busy_q;
    assign O_done          = done_q;
    assign O_pulse_index   = idx_q;
    assign O_match_overrun = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_pw_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pw_trigger_sequencer
// Brief    : Directed bench for pw_trigger_sequencer with hand-computed timing.
// Revision : 1.0
// ============================================================================
module tb_pw_trigger_sequencer;

    localparam int P  = 8;
    localparam int NW = 4;
    localparam int DW = 10;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              I_arm = 1'b0;
    logic              I_trigger_enable = 1'b0;
    logic              I_match = 1'b0;
    logic [NW-1:0]     I_num_triggers = '0;
    logic [DW*P-1:0]   I_trigger_delay = '0;
    logic [DW*P-1:0]   I_trigger_width = '0;
    logic              O_trigger;
    logic              O_busy;
    logic              O_done;
    logic [NW-1:0]     O_pulse_index;
    logic              O_match_overrun;

    int checks = 0;
    int errors = 0;

    pw_trigger_sequencer #(
        .pNUM_TRIGGER_PULSES (P),
        .pNUM_TRIGGER_WIDTH  (NW),
        .pDELAY_WIDTH        (DW)
    ) dut (
        .trigger_clk      (clk),
        .reset_i          (reset_i),
        .I_arm            (I_arm),
        .I_trigger_enable (I_trigger_enable),
        .I_match          (I_match),
        .I_num_triggers   (I_num_triggers),
        .I_trigger_delay  (I_trigger_delay),
        .I_trigger_width  (I_trigger_width),
        .O_trigger        (O_trigger),
        .O_busy           (O_busy),
        .O_done           (O_done),
        .O_pulse_index    (O_pulse_index),
        .O_match_overrun  (O_match_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses {delay,width}: {5,3} {0,2} {2,0}, N=3
    task automatic cfg3();
        I_num_triggers  = 4'd3;
        I_trigger_delay = '0;
        I_trigger_width = '0;
        I_trigger_delay[0*DW +: DW] = 10'd5;
        I_trigger_delay[1*DW +: DW] = 10'd0;
        I_trigger_delay[2*DW +: DW] = 10'd2;
        I_trigger_width[0*DW +: DW] = 10'd3;
        I_trigger_width[1*DW +: DW] = 10'd2;
        I_trigger_width[2*DW +: DW] = 10'd0;
    endtask

    task automatic seq3(input bit mess_cfg, input bit late_match);
        logic [16:0] e_trig;
        int          e_idx;
        e_trig = 17'b00100110111000000;
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        chk("s3_busy_T0", 32'(O_busy), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            if (mess_cfg && k == 1) begin
                I_num_triggers  = 4'd8;
                I_trigger_delay = '1;
                I_trigger_width = '1;
            end
            if (late_match && k == 4) I_match = 1'b1;
            tick();
            I_match = 1'b0;
            e_idx = (k <= 8) ? 0 : (k <= 11) ? 1 : (k <= 15) ? 2 : 0;
            chk($sformatf("s3_trig@%0d", k), 32'(O_trigger), 32'(e_trig[k]));
            chk($sformatf("s3_done@%0d", k), 32'(O_done), 32'(k == 15));
            chk($sformatf("s3_idx@%0d", k), 32'(O_pulse_index), 32'(e_idx));
            chk($sformatf("s3_busy@%0d", k), 32'(O_busy), 32'(k <= 15));
        end
    endtask

    task automatic count_pulses(output int rises, output int dones);
        logic prev;
        rises = 0;
        dones = 0;
        prev  = 1'b0;
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (O_trigger && !prev) rises++;
            if (O_done) dones++;
            prev = O_trigger;
        end
    endtask

    initial begin
        int   r;
        int   d;
        logic acc;

        // Reset state
        tick();
        tick();
        chk("rst_trig", 32'(O_trigger), 32'd0);
        chk("rst_busy", 32'(O_busy), 32'd0);
        chk("rst_done", 32'(O_done), 32'd0);
        chk("rst_idx", 32'(O_pulse_index), 32'd0);
        chk("rst_ovr", 32'(O_match_overrun), 32'd0);
        reset_i = 1'b0;
        I_arm = 1'b1;
        I_trigger_enable = 1'b1;
        tick();

        // Single pulse, zero delay, width 1
        I_num_triggers = 4'd1;
        I_trigger_width[0*DW +: DW] = 10'd1;
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        chk("s1_busy_T0", 32'(O_busy), 32'd1);
        chk("s1_trig_T0", 32'(O_trigger), 32'd0);
        tick();
        chk("s1_trig_T1", 32'(O_trigger), 32'd1);
        chk("s1_done_T1", 32'(O_done), 32'd0);
        tick();
        chk("s1_trig_T2", 32'(O_trigger), 32'd0);
        chk("s1_done_T2", 32'(O_done), 32'd1);
        chk("s1_busy_T2", 32'(O_busy), 32'd1);
        tick();
        chk("s1_busy_T3", 32'(O_busy), 32'd0);
        chk("s1_done_T3", 32'(O_done), 32'd0);

        // Match during DONE: overrun, no restart
        I_match = 1'b1;
        tick();
        tick();
        I_match = 1'b0;
        tick();
        chk("dm_trig_T2", 32'(O_done), 32'd1);
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        chk("dm_busy_T3", 32'(O_busy), 32'd0);
        chk("dm_ovr_T3", 32'(O_match_overrun), 32'd1);
        tick();
        chk("dm_busy_T4", 32'(O_busy), 32'd0);
        chk("dm_trig_T4", 32'(O_trigger), 32'd0);
        I_arm = 1'b0;
        tick();
        I_arm = 1'b1;
        tick();
        chk("dm_ovr_clr", 32'(O_match_overrun), 32'd0);

        // Three-pulse train with config scrambled mid-sequence
        cfg3();
        seq3(1'b1, 1'b0);
        chk("s3_ovr_none", 32'(O_match_overrun), 32'd0);

        // Same train with a second match 4 cycles in
        cfg3();
        seq3(1'b0, 1'b1);
        chk("ov_set", 32'(O_match_overrun), 32'd1);
        I_arm = 1'b0;
        tick();
        chk("ov_hold_armlow", 32'(O_match_overrun), 32'd1);
        I_arm = 1'b1;
        tick();
        chk("ov_clr_armrise", 32'(O_match_overrun), 32'd0);

        // Count clamping: 0 -> 1 pulse, 15 -> 8 pulses
        I_trigger_delay = '0;
        I_trigger_width = '0;
        I_num_triggers = 4'd0;
        count_pulses(r, d);
        chk("n0_pulses", 32'(r), 32'd1);
        chk("n0_dones", 32'(d), 32'd1);
        I_num_triggers = 4'd15;
        count_pulses(r, d);
        chk("n15_pulses", 32'(r), 32'd8);
        chk("n15_dones", 32'(d), 32'd1);

        // Arm dropped during HIGH of pulse 1
        cfg3();
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        chk("ab_trig_T10", 32'(O_trigger), 32'd1);
        chk("ab_idx_T10", 32'(O_pulse_index), 32'd1);
        I_arm = 1'b0;
        tick();
        chk("ab_trig_T11", 32'(O_trigger), 32'd0);
        chk("ab_busy_T11", 32'(O_busy), 32'd0);
        chk("ab_done_T11", 32'(O_done), 32'd0);
        acc = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            acc = acc | O_done | O_trigger | O_busy;
        end
        chk("ab_quiet", 32'(acc), 32'd0);
        I_arm = 1'b1;
        tick();

        // Reset mid-DELAY, then restart from pulse 0
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        tick();
        tick();
        tick();
        chk("rm_busy_pre", 32'(O_busy), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("rm_trig", 32'(O_trigger), 32'd0);
        chk("rm_busy", 32'(O_busy), 32'd0);
        chk("rm_done", 32'(O_done), 32'd0);
        chk("rm_idx", 32'(O_pulse_index), 32'd0);
        tick();
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        chk("rm_trig_T5", 32'(O_trigger), 32'd0);
        tick();
        chk("rm_trig_T6", 32'(O_trigger), 32'd1);
        chk("rm_idx_T6", 32'(O_pulse_index), 32'd0);
        for (int k = 0; k < 30 && O_busy; k++) tick();
        chk("rm_idle", 32'(O_busy), 32'd0);

        // Gating: enable low, then arm low
        I_trigger_enable = 1'b0;
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        acc = O_busy;
        for (int k = 0; k < 8; k++) begin
            tick();
            acc = acc | O_trigger | O_busy;
        end
        chk("gate_en", 32'(acc), 32'd0);
        I_trigger_enable = 1'b1;
        I_arm = 1'b0;
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        acc = O_busy;
        for (int k = 0; k < 8; k++) begin
            tick();
            acc = acc | O_trigger | O_busy;
        end
        chk("gate_arm", 32'(acc), 32'd0);
        I_arm = 1'b1;
        tick();

        // Maximum delay field: pulse at exactly T + 2^DW
        I_num_triggers = 4'd1;
        I_trigger_delay = '0;
        I_trigger_width = '0;
        I_trigger_delay[0*DW +: DW] = '1;
        I_trigger_width[0*DW +: DW] = 10'd1;
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        acc = 1'b0;
        for (int k = 1; k < (1 << DW); k++) begin
            tick();
            acc = acc | O_trigger | O_done;
        end
        chk("max_early", 32'(acc), 32'd0);
        chk("max_busy", 32'(O_busy), 32'd1);
        tick();
        chk("max_trig_hi", 32'(O_trigger), 32'd1);
        tick();
        chk("max_trig_lo", 32'(O_trigger), 32'd0);
        chk("max_done", 32'(O_done), 32'd1);
        tick();
        chk("max_idle", 32'(O_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
